// File: rtl/pool_line_buffer.sv
// pool_line_buffer
//   Streaming 3x3 window generator placed directly upstream of avg_pool / conv. Raster-order
//   pixels are accepted one per beat; two row RAMs hold rows r-1 and r-2, and a 3x3 shift window
//   collects the newest three columns. A one-entry output register presents each window.
//
//   Optional build macro: LB_STRIDE2_EN
//     defined   : windows only at positions where (row-2) and (col-2) are both even (stride 2)
//     undefined : a window at every position with row>=2 and col>=2 (stride 1)
//
// Ports
//   i_clk, i_rst          clock (rising edge) and asynchronous active-high reset
//   i_in_valid/o_in_ready input pixel handshake
//   i_in_sof              accepted pixel is (0,0) of a new frame
//   i_in_pix              input pixel
//   o_win_valid/i_win_ready window handshake
//   o_win                 3x3 window, [8]=top-left (oldest), [0]=bottom-right (newest pixel)
//   o_win_row, o_win_col  position of the window's bottom-right pixel
//   o_frame_done          one-cycle pulse after the last window of a frame is accepted
`timescale 1ns / 1ps

module pool_line_buffer #(
  parameter int unsigned PIX_W = 10,
  parameter int unsigned IMG_W = 18,
  parameter int unsigned IMG_H = 18
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic                          i_in_sof,
  input  logic [PIX_W-1:0]              i_in_pix,
  output logic                          o_win_valid,
  input  logic                          i_win_ready,
  output logic [8:0][PIX_W-1:0]         o_win,
  output logic [$clog2(IMG_H)-1:0]      o_win_row,
  output logic [$clog2(IMG_W)-1:0]      o_win_col,
  output logic                          o_frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

`ifdef LB_STRIDE2_EN
  // (row-2) even is the same as row even: last eligible row/col is the largest even index.
  localparam int unsigned LAST_ROW_I = (IMG_H - 1) - ((IMG_H - 1) % 2);
  localparam int unsigned LAST_COL_I = (IMG_W - 1) - ((IMG_W - 1) % 2);
`else
  localparam int unsigned LAST_ROW_I = IMG_H - 1;
  localparam int unsigned LAST_COL_I = IMG_W - 1;
`endif

  localparam logic [RW-1:0] LAST_ROW = RW'(LAST_ROW_I);
  localparam logic [CW-1:0] LAST_COL = CW'(LAST_COL_I);

  typedef enum logic [1:0] {
    StFill,
    StStream,
    StDone
  } state_t;

  // Storage
  logic [PIX_W-1:0]      r_ram1 [IMG_W];  // row r-1
  logic [PIX_W-1:0]      r_ram2 [IMG_W];  // row r-2
  logic [8:0][PIX_W-1:0] r_shift;

  // Counters, FSM and output register
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_win_valid;
  logic [8:0][PIX_W-1:0] r_win;
  logic [RW-1:0]         r_win_row;
  logic [CW-1:0]         r_win_col;
  logic                  r_win_last;

  logic                  w_accept;
  logic                  w_eligible;
  logic                  w_last_pos;
  logic                  w_win_take;
  logic [CW-1:0]         w_col;
  logic [RW-1:0]         w_row;
  logic [CW-1:0]         w_col_nxt;
  logic [RW-1:0]         w_row_nxt;
  logic [RW-1:0]         w_row_after;
  logic [PIX_W-1:0]      w_up1;
  logic [PIX_W-1:0]      w_up2;
  logic [8:0][PIX_W-1:0] w_shift;

  assign o_in_ready = ~r_win_valid | i_win_ready;
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_win_take = r_win_valid & i_win_ready;

  always_comb begin
    // Start-of-frame forces the accepted pixel to position (0,0).
    w_col = i_in_sof ? '0 : r_col;
    w_row = i_in_sof ? '0 : r_row;

    w_up1 = r_ram1[w_col];
    w_up2 = r_ram2[w_col];

    // Shift left: each window row drops its oldest column and takes the new one on the right.
    w_shift = {r_shift[7:6], w_up2, r_shift[4:3], w_up1, r_shift[1:0], i_in_pix};

    w_eligible = (w_row >= RW'(2)) && (w_col >= CW'(2));
`ifdef LB_STRIDE2_EN
    w_eligible = w_eligible && !w_row[0] && !w_col[0];
`endif
    w_last_pos = (w_row == LAST_ROW) && (w_col == LAST_COL);

    if (w_col == COL_MAX) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == ROW_MAX) ? '0 : w_row + RW'(1);
    end else begin
      w_col_nxt = w_col + CW'(1);
      w_row_nxt = w_row;
    end
  end

  // Next-state: DONE for one cycle once the frame's last window leaves; otherwise the state
  // tracks whether the row counter has reached the streaming region.
  always_comb begin
    w_state_nxt = r_state;
    w_row_after = w_accept ? w_row_nxt : r_row;
    if (w_win_take && r_win_last) begin
      w_state_nxt = StDone;
    end else if (w_row_after >= RW'(2)) begin
      w_state_nxt = StStream;
    end else begin
      w_state_nxt = StFill;
    end
  end

  // Row RAMs: no reset; rows 0..1 of every frame rewrite them before any window reads them.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_ram1[w_col] <= i_in_pix;
      r_ram2[w_col] <= w_up1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_shift     <= '0;
      r_state     <= StFill;
      r_win_valid <= 1'b0;
      r_win       <= '0;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_win_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_col   <= w_col_nxt;
        r_row   <= w_row_nxt;
        r_shift <= w_shift;
      end
      // Accept implies the output slot is free or being emptied this cycle.
      if (w_accept && w_eligible) begin
        r_win_valid <= 1'b1;
        r_win       <= w_shift;
        r_win_row   <= w_row;
        r_win_col   <= w_col;
        r_win_last  <= w_last_pos;
      end else if (i_win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign o_win_valid  = r_win_valid;
  assign o_win        = r_win;
  assign o_win_row    = r_win_row;
  assign o_win_col    = r_win_col;
  assign o_frame_done = (r_state == StDone);

endmodule

// File: tb/tb_pool_line_buffer.sv
// Testbench for pool_line_buffer on a 4x4 image: directed frames with hand-computed windows,
// a stall, a mid-frame reset, a mid-frame start-of-frame and three randomly gapped frames.
// A small image-array model builds the expected window stream.
`timescale 1ns / 1ps

module tb_pool_line_buffer;

  localparam int unsigned PW = 10;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
`ifdef LB_STRIDE2_EN
  localparam int WPF    = 1;
  localparam int LAST_R = 2;
  localparam int LAST_C = 2;
`else
  localparam int WPF    = 4;
  localparam int LAST_R = 3;
  localparam int LAST_C = 3;
`endif

  logic                  i_clk;
  logic                  i_rst;
  logic                  i_in_valid;
  logic                  o_in_ready;
  logic                  i_in_sof;
  logic [PW-1:0]         i_in_pix;
  logic                  o_win_valid;
  logic                  i_win_ready = 1'b1;
  logic [8:0][PW-1:0]    o_win;
  logic [1:0]            o_win_row;
  logic [1:0]            o_win_col;
  logic                  o_frame_done;

  pool_line_buffer #(
    .PIX_W(PW),
    .IMG_W(W),
    .IMG_H(H)
  ) u_dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_sof    (i_in_sof),
    .i_in_pix    (i_in_pix),
    .o_win_valid (o_win_valid),
    .i_win_ready (i_win_ready),
    .o_win       (o_win),
    .o_win_row   (o_win_row),
    .o_win_col   (o_win_col),
    .o_frame_done(o_frame_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;
  int win_cnt = 0;
  int fd_cnt = 0;
  int rdy_mode = 0;  // 0: ready high, 1: ready low, 2: random

  logic [8:0][PW-1:0] first_win;
  logic [1:0]         first_row;
  logic [1:0]         first_col;
  bit                 first_seen = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge i_clk) begin
    #2;
    case (rdy_mode)
      0:       i_win_ready = 1'b1;
      1:       i_win_ready = 1'b0;
      default: i_win_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: image array for the current frame plus an expected-window queue.
  typedef struct {
    logic [8:0][PW-1:0] win;
    int                 row;
    int                 col;
    bit                 last;
  } exp_t;

  exp_t          sb_q[$];
  logic [PW-1:0] img [H][W];
  int            mr = 0;
  int            mc = 0;
  bit            fd_pend = 1'b0;

  always @(negedge i_clk) begin
    exp_t e;
    exp_t n;
    bit   elig;
    if (i_rst) begin
      mr = 0;
      mc = 0;
      fd_pend = 1'b0;
      sb_q.delete();
    end else begin
      check("frame_done", 128'(o_frame_done), 128'(fd_pend));
      check("in_ready", 128'(o_in_ready), 128'(!o_win_valid || i_win_ready));
      if (o_frame_done) fd_cnt++;
      fd_pend = 1'b0;
      if (o_win_valid && i_win_ready) begin
        win_cnt++;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_win  = o_win;
          first_row  = o_win_row;
          first_col  = o_win_col;
        end
        if (sb_q.size() == 0) begin
          check("win_unexpected", 128'(1), 128'(0));
        end else begin
          e = sb_q.pop_front();
          check("win", 128'(o_win), 128'(e.win));
          check("win_row", 128'(o_win_row), 128'(e.row));
          check("win_col", 128'(o_win_col), 128'(e.col));
          fd_pend = e.last;
        end
      end
      if (i_in_valid && o_in_ready) begin
        if (i_in_sof) begin
          mr = 0;
          mc = 0;
        end
        img[mr][mc] = i_in_pix;
        elig = (mr >= 2) && (mc >= 2);
`ifdef LB_STRIDE2_EN
        elig = elig && (mr % 2 == 0) && (mc % 2 == 0);
`endif
        if (elig) begin
          n.win  = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                    img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                    img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
          n.row  = mr;
          n.col  = mc;
          n.last = (mr == LAST_R) && (mc == LAST_C);
          sb_q.push_back(n);
        end
        if (mc == W - 1) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
          mc = mc + 1;
        end
      end
    end
  end

  task automatic send(input logic [PW-1:0] pix, input bit sof);
    bit got = 1'b0;
    int guard = 0;
    i_in_valid = 1'b1;
    i_in_pix   = pix;
    i_in_sof   = sof;
    while (!got && guard < 100) begin
      @(negedge i_clk);
      got = o_in_ready;
      @(posedge i_clk);
      #1;
      guard++;
    end
    if (!got) check("send_timeout", 128'(0), 128'(1));
    i_in_valid = 1'b0;
    i_in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    i_in_valid = 1'b0;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic ramp_frame(input int base);
    for (int k = 0; k < W * H; k++) send(PW'(base + k), 1'b0);
  endtask

  logic [8:0][PW-1:0] exp_first;
  int                 w0;
  int                 f0;

  initial begin
    i_rst      = 1'b1;
    i_in_valid = 1'b0;
    i_in_sof   = 1'b0;
    i_in_pix   = '0;
    exp_first  = {10'd0, 10'd1, 10'd2, 10'd4, 10'd5, 10'd6, 10'd8, 10'd9, 10'd10};

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_win_valid", 128'(o_win_valid), 128'(0));
    check("rst_frame_done", 128'(o_frame_done), 128'(0));
    check("rst_win", 128'(o_win), 128'(0));
    check("rst_win_row", 128'(o_win_row), 128'(0));
    check("rst_win_col", 128'(o_win_col), 128'(0));
    check("rst_in_ready", 128'(o_in_ready), 128'(1));
    i_rst = 1'b0;

    // Test 1: continuous ramp frame, ready always high
    first_seen = 1'b0;
    w0 = win_cnt;
    f0 = fd_cnt;
    ramp_frame(0);
    idle(6);
    check("t1_first_win", 128'(first_win), 128'(exp_first));
    check("t1_first_row", 128'(first_row), 128'(2));
    check("t1_first_col", 128'(first_col), 128'(2));
    check("t1_win_count", 128'(win_cnt - w0), 128'(WPF));
    check("t1_frame_done", 128'(fd_cnt - f0), 128'(1));

    // Test 3: stall at the first window for 5 cycles
    first_seen = 1'b0;
    w0 = win_cnt;
    f0 = fd_cnt;
    rdy_mode = 1;
    for (int k = 0; k <= 10; k++) send(PW'(k), 1'b0);
    i_in_valid = 1'b1;
    i_in_pix   = PW'(11);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("t3_stall_in_ready", 128'(o_in_ready), 128'(0));
      check("t3_stall_valid", 128'(o_win_valid), 128'(1));
      check("t3_stall_win", 128'(o_win), 128'(exp_first));
      @(posedge i_clk);
      #1;
    end
    rdy_mode = 0;
    for (int k = 11; k < W * H; k++) send(PW'(k), 1'b0);
    idle(6);
    check("t3_first_win", 128'(first_win), 128'(exp_first));
    check("t3_win_count", 128'(win_cnt - w0), 128'(WPF));
    check("t3_frame_done", 128'(fd_cnt - f0), 128'(1));

    // Test 4: reset after 7 accepted pixels, then a full frame
    for (int k = 0; k < 7; k++) send(PW'(k), 1'b0);
    i_rst = 1'b1;
    #1;
    check("t4_rst_win_valid", 128'(o_win_valid), 128'(0));
    check("t4_rst_win", 128'(o_win), 128'(0));
    check("t4_rst_frame_done", 128'(o_frame_done), 128'(0));
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    first_seen = 1'b0;
    w0 = win_cnt;
    f0 = fd_cnt;
    ramp_frame(0);
    idle(6);
    check("t4_first_win", 128'(first_win), 128'(exp_first));
    check("t4_win_count", 128'(win_cnt - w0), 128'(WPF));
    check("t4_frame_done", 128'(fd_cnt - f0), 128'(1));

    // Test 5: start-of-frame on pixel 9 of a frame
    first_seen = 1'b0;
    w0 = win_cnt;
    f0 = fd_cnt;
    for (int k = 0; k < 9; k++) send(PW'(100 + k), 1'b0);
    send(PW'(200), 1'b1);
    for (int k = 1; k < W * H; k++) send(PW'(200 + k), 1'b0);
    idle(6);
    check("t5_first_win", 128'(first_win),
          128'({10'd200, 10'd201, 10'd202, 10'd204, 10'd205, 10'd206, 10'd208, 10'd209,
                10'd210}));
    check("t5_first_row", 128'(first_row), 128'(2));
    check("t5_first_col", 128'(first_col), 128'(2));
    check("t5_win_count", 128'(win_cnt - w0), 128'(WPF));
    check("t5_frame_done", 128'(fd_cnt - f0), 128'(1));

    // Test 6: three back-to-back frames with random input gaps and random ready
    w0 = win_cnt;
    f0 = fd_cnt;
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < W * H; k++) begin
        idle($urandom_range(0, 2));
        send(PW'($urandom_range(0, 1023)), k == 0);
      end
    end
    rdy_mode = 0;
    idle(8);
    check("t6_win_count", 128'(win_cnt - w0), 128'(3 * WPF));
    check("t6_frame_done", 128'(fd_cnt - f0), 128'(3));
    check("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
